// File: rtl/conv_window_buf.sv
// conv_window_buf
// Streaming sliding-window line buffer. Pixels arrive in raster order, all
// channels in parallel, one per valid/ready handshake. A shift chain spanning
// (K-1) full rows plus K pixels exposes every element of a KxK window as a fixed
// tap. A window is registered on the output only when the accepted pixel
// completes a legal (stride-aligned) window position.

module conv_window_buf #(
    parameter int datatype_size = 8,
    parameter int channels      = 1,
    parameter int img_width     = 28,
    parameter int img_height    = 28,
    parameter int kernel_dim    = 3,
    parameter int stride        = 1
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    i_valid,
    output logic                                                    o_ready,
    input  logic [channels*datatype_size-1:0]                       i_data,
    output logic                                                    o_valid,
    input  logic                                                    i_ready,
    output logic [kernel_dim*kernel_dim*channels*datatype_size-1:0] o_data,
    output logic                                                    o_last
);

    localparam int PIX_W = channels * datatype_size;
    localparam int K     = kernel_dim;
    localparam int W     = img_width;
    localparam int H     = img_height;
    localparam int L     = W * (K - 1) + K;
    localparam int WIN_W = K * K * PIX_W;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
    localparam int PH_W  = (stride > 1) ? $clog2(stride) : 1;

    // Position of the final window of a frame. When (H-K) is a multiple of the
    // stride the last legal row is H-1; deriving it from the stride keeps
    // exactly one o_last per frame for every legal geometry.
    localparam int LAST_COL = K - 1 + stride * ((W - K) / stride);
    localparam int LAST_ROW = K - 1 + stride * ((H - K) / stride);

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                state_reg;
    logic                  acc;
    logic [PIX_W-1:0]      shift_reg  [L];
    logic [PIX_W-1:0]      shift_next [L];
    logic [WIN_W-1:0]      taps;

    logic [COL_W-1:0]      col_reg, col_next;
    logic [ROW_W-1:0]      row_reg, row_next;
    logic [PH_W-1:0]       col_ph_reg, col_ph_next, col_ph_step;
    logic [PH_W-1:0]       row_ph_reg, row_ph_next, row_ph_step;
    logic                  col_end, row_end;
    logic                  col_past_fill, row_past_fill;
    logic                  win_legal, win_last;

    logic                  o_valid_reg;
    logic                  o_last_reg;
    logic [WIN_W-1:0]      o_data_reg;

    // A pixel can be taken whenever the output slot is empty or being drained.
    assign o_ready = !o_valid_reg || i_ready;
    assign acc     = i_valid && o_ready;

    assign o_valid = o_valid_reg;
    assign o_last  = o_last_reg;
    assign o_data  = o_data_reg;

    // Post-shift view of the chain: entry 0 is the pixel being accepted, so the
    // window captured on this edge already includes it.
    genvar gi, gj;
    generate
        for (gi = 0; gi < L; gi++) begin : g_shift_next
            if (gi == 0) begin : g_head
                assign shift_next[gi] = i_data;
            end else begin : g_body
                assign shift_next[gi] = shift_reg[gi-1];
            end
        end

        // Window element (r,c) sits (K-1-r) rows and (K-1-c) pixels behind the newest pixel.
        for (gi = 0; gi < K; gi++) begin : g_tap_row
            for (gj = 0; gj < K; gj++) begin : g_tap_col
                assign taps[(gi*K+gj)*PIX_W +: PIX_W] = shift_next[(K-1-gi)*W + (K-1-gj)];
            end
        end
    endgenerate

    // Shift chain advances by one entry per accepted pixel and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < L; j++) begin
                shift_reg[j] <= '0;
            end
        end else if (acc) begin
            for (int j = 0; j < L; j++) begin
                shift_reg[j] <= shift_next[j];
            end
        end
    end

    assign col_end       = (col_reg == COL_W'(W - 1));
    assign row_end       = (row_reg == ROW_W'(H - 1));
    assign col_past_fill = (col_reg >= COL_W'(K - 1));
    assign row_past_fill = (row_reg >= ROW_W'(K - 1));

    // Stride phases count modulo stride from the first full-window column/row,
    // so a phase of zero marks a stride-aligned position without a divider.
    assign col_ph_step = (col_ph_reg == PH_W'(stride - 1)) ? '0 : col_ph_reg + 1'b1;
    assign row_ph_step = (row_ph_reg == PH_W'(stride - 1)) ? '0 : row_ph_reg + 1'b1;

    // Next raster position and stride phases after the current pixel is accepted.
    always_comb begin
        col_next    = col_reg + 1'b1;
        row_next    = row_reg;
        col_ph_next = col_ph_reg;
        row_ph_next = row_ph_reg;
        if (col_end) begin
            col_next    = '0;
            col_ph_next = '0;
            if (row_end) begin
                row_next    = '0;
                row_ph_next = '0;
            end else begin
                row_next = row_reg + 1'b1;
                if (row_past_fill) begin
                    row_ph_next = row_ph_step;
                end
            end
        end else if (col_past_fill) begin
            col_ph_next = col_ph_step;
        end
    end

    // Position counters track the pixel currently offered for acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg    <= '0;
            row_reg    <= '0;
            col_ph_reg <= '0;
            row_ph_reg <= '0;
        end else if (acc) begin
            col_reg    <= col_next;
            row_reg    <= row_next;
            col_ph_reg <= col_ph_next;
            row_ph_reg <= row_ph_next;
        end
    end

    // STREAM is entered exactly when the row counter reaches K-1, so it doubles
    // as the vertical fill gate; stale storage from a previous frame is never emitted.
    assign win_legal = (state_reg == STREAM) && col_past_fill &&
                       (col_ph_reg == '0) && (row_ph_reg == '0);
    assign win_last  = (row_reg == ROW_W'(LAST_ROW)) && (col_reg == COL_W'(LAST_COL));

    // Fill/stream sequencing and the registered window output slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FILL;
            o_valid_reg <= 1'b0;
            o_last_reg  <= 1'b0;
            o_data_reg  <= '0;
        end else begin
            if (acc) begin
                case (state_reg)
                    FILL: begin
                        if (col_end && row_reg == ROW_W'(K - 2)) begin
                            state_reg <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (col_end && row_end) begin
                            state_reg <= FILL;
                        end
                    end
                endcase
            end

            if (acc && win_legal) begin
                o_data_reg  <= taps;
                o_valid_reg <= 1'b1;
                o_last_reg  <= win_last;
            end else if (i_ready) begin
                o_valid_reg <= 1'b0;
                o_last_reg  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buf.sv
// Testbench for conv_window_buf. Four geometries run side by side; each has a
// reference model that keeps the received frame as a 2-D image and cuts
// windows out of it, a scoreboard queue, and an independent output monitor.
`timescale 1ns/1ps

module tb_conv_window_buf;

    localparam int DS   = 8;
    localparam int MAXW = 160;
    localparam int NCFG = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    task automatic check(input int cfg, input bit ok, input string name,
                         input logic [MAXW-1:0] act, input logic [MAXW-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cfg%0d %s: got %h expected %h", cfg, name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int W       = (gi == 0) ? 4 : (gi == 1) ? 5 : (gi == 2) ? 3 : 6;
        localparam int H       = W;
        localparam int K       = 3;
        localparam int S       = (gi == 1) ? 2 : 1;
        localparam int CH      = (gi == 2) ? 2 : 1;
        localparam int DW      = CH * DS;
        localparam int OW      = K * K * DW;
        localparam int NWIN    = ((H - K) / S + 1) * ((W - K) / S + 1);
        localparam int NFRAMES = (gi == 0) ? 5 : (gi == 1) ? 2 : (gi == 2) ? 1 : 3;
        localparam bit GAPS    = (gi == 3);

        logic          rst;
        logic          i_valid;
        logic          o_ready;
        logic [DW-1:0] i_data;
        logic          o_valid;
        logic          i_ready;
        logic [OW-1:0] o_data;
        logic          o_last;

        typedef struct {
            logic [OW-1:0] data;
            bit            last;
            time           t;
            bit            seen;
        } win_t;

        win_t          q[$];
        logic [DW-1:0] img [H][W];
        int            pix      = 0;
        int            win_cnt  = 0;
        int            last_cnt = 0;
        bit            stall_arm = 1'b0;

        conv_window_buf #(
            .datatype_size(DS),
            .channels     (CH),
            .img_width    (W),
            .img_height   (H),
            .kernel_dim   (K),
            .stride       (S)
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .i_valid(i_valid),
            .o_ready(o_ready),
            .i_data (i_data),
            .o_valid(o_valid),
            .i_ready(i_ready),
            .o_data (o_data),
            .o_last (o_last)
        );

        // A raster index is a window position when a full KxK block ends there
        // and both offsets from the first such block are multiples of the stride.
        function automatic bit legal(input int p);
            int x;
            int y;
            x = p % W;
            y = p / W;
            return (y >= K - 1) && (x >= K - 1) &&
                   ((y - (K - 1)) % S == 0) && ((x - (K - 1)) % S == 0);
        endfunction

        // Reference model: on each handshake store the pixel in the frame image;
        // if it closes a window, cut that window out of the image.
        initial begin : trk
            win_t e;
            int   x;
            int   y;
            forever begin
                @(negedge clk);
                if (rst) begin
                    pix = 0;
                    q.delete();
                end else if (i_valid && o_ready) begin
                    x = pix % W;
                    y = pix / W;
                    img[y][x] = i_data;
                    if (legal(pix)) begin
                        e.data = '0;
                        for (int r = 0; r < K; r++) begin
                            for (int c = 0; c < K; c++) begin
                                e.data[(r*K+c)*DW +: DW] = img[y-(K-1)+r][x-(K-1)+c];
                            end
                        end
                        e.last = 1'b1;
                        for (int p2 = pix + 1; p2 < W * H; p2++) begin
                            if (legal(p2)) e.last = 1'b0;
                        end
                        e.t    = $time + 5;
                        e.seen = 1'b0;
                        q.push_back(e);
                    end
                    pix = (pix + 1) % (W * H);
                end
            end
        end

        // Output monitor: compares whatever is presented against the queue head.
        initial begin : mon
            forever begin
                @(negedge clk);
                if (!rst) begin
                    check(gi, o_ready == (!o_valid || i_ready), "o_ready",
                          MAXW'(o_ready), MAXW'(!o_valid || i_ready));
                    if (o_valid) begin
                        check(gi, q.size() != 0, "unexpected window", MAXW'(o_data), MAXW'(0));
                        if (q.size() != 0) begin
                            check(gi, o_data == q[0].data, "window data",
                                  MAXW'(o_data), MAXW'(q[0].data));
                            check(gi, o_last == q[0].last, "o_last",
                                  MAXW'(o_last), MAXW'(q[0].last));
                            if (!q[0].seen) begin
                                check(gi, $time == q[0].t + 5, "latency",
                                      MAXW'($time), MAXW'(q[0].t + 5));
                                q[0].seen = 1'b1;
                            end
                            if (i_ready) begin
                                win_cnt++;
                                if (o_last) last_cnt++;
                                $display("cfg%0d window %0d last=%0b data=%h",
                                         gi, win_cnt, o_last, o_data);
                                void'(q.pop_front());
                            end
                        end
                    end
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic do_reset();
            rst = 1'b1;
            @(negedge clk);
            check(gi, o_valid == 1'b0, "reset o_valid", MAXW'(o_valid), MAXW'(0));
            check(gi, o_last == 1'b0, "reset o_last", MAXW'(o_last), MAXW'(0));
            check(gi, o_data == '0, "reset o_data", MAXW'(o_data), MAXW'(0));
            step();
            rst = 1'b0;
        endtask

        task automatic send(input logic [DW-1:0] d);
            bit acc;
            int n;
            if (GAPS) begin
                while ($urandom_range(1) == 1) begin
                    i_valid = 1'b0;
                    step();
                end
            end
            i_valid = 1'b1;
            i_data  = d;
            acc     = 1'b0;
            n       = 0;
            while (!acc && n < 200) begin
                @(negedge clk);
                acc = o_ready;
                step();
                n++;
            end
            check(gi, acc, "accept timeout", MAXW'(acc), MAXW'(1));
            i_valid = 1'b0;
        endtask

        // kind 0: channel ch carries ch*100 + p; otherwise random pixels.
        task automatic send_frame(input int kind);
            logic [DW-1:0] d;
            for (int p = 0; p < W * H; p++) begin
                if (kind == 0) begin
                    for (int ch = 0; ch < CH; ch++) d[ch*DS +: DS] = DS'(ch * 100 + p);
                end else begin
                    d = DW'($urandom);
                end
                send(d);
            end
        endtask

        task automatic finish_cfg();
            i_valid = 1'b0;
            repeat (40) step();
            check(gi, win_cnt == NWIN * NFRAMES, "window count",
                  MAXW'(win_cnt), MAXW'(NWIN * NFRAMES));
            check(gi, last_cnt == NFRAMES, "o_last count", MAXW'(last_cnt), MAXW'(NFRAMES));
            check(gi, q.size() == 0, "pending windows", MAXW'(q.size()), MAXW'(0));
            done_cnt++;
        endtask

        if (gi == 0) begin : g_seq0
            // Counting frame, stalled frame, two back-to-back frames, a frame cut
            // by reset after pixel 7, then the counting frame again.
            initial begin
                i_valid = 1'b0;
                i_ready = 1'b1;
                i_data  = '0;
                do_reset();
                send_frame(0);
                repeat (3) step();
                stall_arm = 1'b1;
                send_frame(1);
                send_frame(1);
                send_frame(1);
                for (int p = 0; p < 8; p++) send(DW'(p));
                do_reset();
                send_frame(0);
                finish_cfg();
            end

            // Hold i_ready low through the first window of the armed frame.
            initial begin : stall
                logic [OW-1:0] held;
                bit            found;
                int            n;
                wait (stall_arm);
                i_ready = 1'b0;
                found   = 1'b0;
                n       = 0;
                while (!found && n < 200) begin
                    @(negedge clk);
                    found = o_valid;
                    n++;
                end
                check(gi, found, "stall window timeout", MAXW'(found), MAXW'(1));
                held = o_data;
                repeat (5) begin
                    @(negedge clk);
                    check(gi, o_valid == 1'b1, "stall o_valid", MAXW'(o_valid), MAXW'(1));
                    check(gi, o_ready == 1'b0, "stall o_ready", MAXW'(o_ready), MAXW'(0));
                    check(gi, o_data == held, "stall o_data", MAXW'(o_data), MAXW'(held));
                end
                step();
                i_ready = 1'b1;
            end
        end else if (gi == 3) begin : g_seq3
            initial begin
                i_valid = 1'b0;
                i_ready = 1'b1;
                i_data  = '0;
                do_reset();
                for (int f = 0; f < NFRAMES; f++) send_frame(1);
                finish_cfg();
            end

            initial begin : rnd_ready
                forever begin
                    step();
                    i_ready = ($urandom_range(1) == 1);
                end
            end
        end else begin : g_seq_plain
            initial begin
                i_valid = 1'b0;
                i_ready = 1'b1;
                i_data  = '0;
                do_reset();
                for (int f = 0; f < NFRAMES; f++) send_frame(f);
                finish_cfg();
            end
        end

        if (gi == 2) begin : g_ch_chk
            // Two-channel frame: element (r,c) carries 3r+c and 100+3r+c.
            initial begin : ch_chk
                logic [DS-1:0] e0;
                logic [DS-1:0] e1;
                forever begin
                    @(negedge clk);
                    if (!rst && o_valid) begin
                        for (int r = 0; r < K; r++) begin
                            for (int c = 0; c < K; c++) begin
                                e0 = o_data[((r*K+c)*CH+0)*DS +: DS];
                                e1 = o_data[((r*K+c)*CH+1)*DS +: DS];
                                check(gi, e0 == DS'(3*r+c), "ch0 element",
                                      MAXW'(e0), MAXW'(3*r+c));
                                check(gi, e1 == DS'(100+3*r+c), "ch1 element",
                                      MAXW'(e1), MAXW'(100+3*r+c));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : top
        int n;
        n = 0;
        while (done_cnt < NCFG && n < 50000) begin
            @(negedge clk);
            n++;
        end
        check(-1, done_cnt == NCFG, "completion timeout", MAXW'(done_cnt), MAXW'(NCFG));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
